// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - In-order {PC, instruction} queue between IF and ID stages.
// Optional build macro IFQ_NOP_FILL_EN: present addi x0,x0,0 at PC 0 while the queue is empty.
module if_id_queue #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      PC_if,
  input  logic [31:0]      Instruction_if,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic             IF_flush,
  output logic [31:0]      PC_id,
  output logic [31:0]      Instruction_id,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic             push;
  logic             pop;
  logic [63:0]      head;

  // if_ready depends only on occupancy, keeping ID's stall off the IF path.
  assign if_ready = (count != FULL);
  assign id_valid = (count != '0);
  assign push     = if_valid && if_ready;
  assign pop      = id_valid && id_ready;
  assign head     = mem[rp];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (IF_flush) begin
      // Redirect: drop everything queued and any push arriving with it.
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= {PC_if, Instruction_if};
        wp      <= wp + PTR_W'(1);
      end
      if (pop) begin
        rp <= rp + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef IFQ_NOP_FILL_EN
  assign PC_id          = id_valid ? head[63:32] : 32'h0000_0000;
  assign Instruction_id = id_valid ? head[31:0]  : 32'h0000_0013;
`else
  assign PC_id          = head[63:32];
  assign Instruction_id = head[31:0];
`endif

endmodule
